// File: rtl/zero_padding_unit_if.sv
// Stream bundle between the upstream feature-map buffer and the convolution engine.
interface zero_padding_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  en_padding;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_last;
  logic                  pad_active;

  modport slave (
    input  in_valid, en_padding, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last, pad_active
  );

  modport master (
    output in_valid, en_padding, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last, pad_active
  );
endinterface

// File: rtl/zero_padding_unit.sv
// Single registered stage that forwards words, optionally zeroing them, and in
// frame mode wraps each IMG_W x IMG_H frame in a PAD-wide ring of zeros.
module zero_padding_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PAD        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_pad_en,
  zero_padding_unit_if.slave  bus
);
  localparam int FW = IMG_W + 2*PAD;
  localparam int FH = IMG_H + 2*PAD;
  localparam int CW = $clog2(FW);
  localparam int RW = $clog2(FH);

  localparam logic [CW-1:0] COL_LO  = CW'(PAD);
  localparam logic [CW-1:0] COL_HI  = CW'(IMG_W + PAD);
  localparam logic [CW-1:0] COL_MAX = CW'(FW - 1);
  localparam logic [RW-1:0] ROW_LO  = RW'(PAD);
  localparam logic [RW-1:0] ROW_HI  = RW'(IMG_H + PAD);
  localparam logic [RW-1:0] ROW_MAX = RW'(FH - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          load_ok, border, gen, take, emit, at_last;

  assign load_ok = !bus.out_valid || bus.out_ready;
  assign border  = (col < COL_LO) || (col >= COL_HI) || (row < ROW_LO) || (row >= ROW_HI);
  assign at_last = (col == COL_MAX) && (row == ROW_MAX);

  // in_ready never looks at in_valid, so upstream can't form a comb loop through us
  assign bus.in_ready = load_ok && (!auto_pad_en || !border);
  assign gen  = auto_pad_en && border && load_ok;
  assign take = bus.in_valid && bus.in_ready;
  assign emit = gen || take;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.out_last   <= 1'b0;
      bus.pad_active <= 1'b0;
    end else if (emit) begin
      bus.out_valid  <= 1'b1;
      bus.data_out   <= (gen || bus.en_padding) ? '0 : bus.data_in;
      bus.pad_active <= gen || bus.en_padding;
      bus.out_last   <= auto_pad_en && at_last;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

  // Position of the next word to be emitted, row-major
  always_ff @(posedge clk) begin
    if (rst || !auto_pad_en) begin
      col <= '0;
      row <= '0;
    end else if (emit) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_zero_padding_unit.sv
// Bench for zero_padding_unit: vector table, hand sequences and random traffic
// scored against a slot-list model of the padded frame.
module tb_zero_padding_unit;
  localparam int IMG_W = 2;
  localparam int IMG_H = 2;
  localparam int PAD   = 1;
  localparam int FW    = IMG_W + 2*PAD;
  localparam int FH    = IMG_H + 2*PAD;
  localparam int NSLOT = FW * FH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic apad = 1'b0;
  always #5 clk = ~clk;

  zero_padding_unit_if #(.DATA_WIDTH(32)) bus ();

  zero_padding_unit #(.DATA_WIDTH(32), .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD(PAD)) dut (
    .clk(clk), .rst(rst), .auto_pad_en(apad), .bus(bus)
  );

  typedef struct { logic [31:0] d; logic pad; logic last; } exp_t;
  typedef struct { logic en; logic [31:0] din; logic [31:0] exp_d; logic exp_pad; } vec_t;

  exp_t        exp_q[$];
  logic [31:0] log_q[$];
  logic [31:0] frame_in[4];
  logic [31:0] exp_frame[NSLOT];
  int gen_idx = 0, frames_done = 0, errors = 0, checks = 0;
  logic acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit interior(input int idx);
    int r, c;
    r = idx / FW;
    c = idx % FW;
    return (r >= PAD) && (r < PAD + IMG_H) && (c >= PAD) && (c < PAD + IMG_W);
  endfunction

  function automatic void advance();
    gen_idx++;
    if (gen_idx == NSLOT) begin
      gen_idx = 0;
      frames_done++;
    end
  endfunction

  // One clock: drive at negedge, check the settled outputs, update the model
  task automatic step(input logic ap, input logic iv, input logic [31:0] d,
                      input logic en, input logic ordy, output logic accepted);
    exp_t e;
    logic ov_m, lok, exp_ir;
    @(negedge clk);
    rst = 1'b0; apad = ap;
    bus.in_valid = iv; bus.data_in = d; bus.en_padding = en; bus.out_ready = ordy;
    #1;
    ov_m   = (exp_q.size() != 0);
    lok    = !ov_m || ordy;
    exp_ir = lok && (!ap || interior(gen_idx));
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, ov_m});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ir});
    if (ov_m && ordy) begin
      e = exp_q.pop_front();
      chk("data_out", bus.data_out, e.d);
      chk("pad_active", {31'b0, bus.pad_active}, {31'b0, e.pad});
      chk("out_last", {31'b0, bus.out_last}, {31'b0, e.last});
      log_q.push_back(bus.data_out);
    end
    accepted = iv && exp_ir;
    if (!ap) begin
      if (accepted) exp_q.push_back('{en ? 32'h0 : d, en, 1'b0});
    end else if (lok) begin
      if (interior(gen_idx)) begin
        if (iv) begin
          exp_q.push_back('{en ? 32'h0 : d, en, gen_idx == NSLOT-1});
          advance();
        end
      end else begin
        exp_q.push_back('{32'h0, 1'b1, gen_idx == NSLOT-1});
        advance();
      end
    end
  endtask

  task automatic reset_chk(input logic ap);
    @(negedge clk);
    rst = 1'b1; apad = ap; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_out_last", {31'b0, bus.out_last}, 32'd0);
    chk("rst_pad_active", {31'b0, bus.pad_active}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, ap ? 32'd0 : 32'd1);
    exp_q.delete();
    gen_idx = 0;
  endtask

  // Full-throughput frame fed from frame_in, then popped out in bypass mode
  task automatic full_frame(input string tag);
    int k, n, f0;
    logic a;
    k = 0; n = 0; f0 = frames_done;
    log_q.delete();
    while (frames_done == f0 && n < 40) begin
      step(1'b1, 1'b1, frame_in[(k > 3) ? 0 : k], 1'b0, 1'b1, a);
      if (a) k++;
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, n, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a);
    chk({tag, "_consumed"}, k, 32'd4);
    chk({tag, "_count"}, log_q.size(), NSLOT);
    for (int i = 0; i < NSLOT && i < log_q.size(); i++)
      chk({tag, "_seq"}, log_q[i], exp_frame[i]);
  endtask

  vec_t tv[4];

  initial begin
    int n, f0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.en_padding = 1'b0; bus.out_ready = 1'b1;
    tv[0] = '{1'b1, 32'h41900000, 32'h00000000, 1'b1};
    tv[1] = '{1'b1, 32'h41900002, 32'h00000000, 1'b1};
    tv[2] = '{1'b1, 32'h41900008, 32'h00000000, 1'b1};
    tv[3] = '{1'b0, 32'h41900008, 32'h41900008, 1'b0};
    frame_in = '{32'd1, 32'd2, 32'd3, 32'd4};
    exp_frame = '{0, 0, 0, 0,  0, 1, 2, 0,  0, 3, 4, 0,  0, 0, 0, 0};

    reset_chk(1'b0);

    // Bypass vectors on consecutive cycles, each checked one cycle later
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, tv[i].din, tv[i].en, 1'b1, acc);
      chk("tbl_accept", {31'b0, acc}, 32'd1);
      @(posedge clk); #1;
      chk("tbl_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("tbl_data", bus.data_out, tv[i].exp_d);
      chk("tbl_pad", {31'b0, bus.pad_active}, {31'b0, tv[i].exp_pad});
    end

    // Bypass backpressure: B stays offered while A is stuck
    step(1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hBBBB0002, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 32'hBBBB0002, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);

    // Random bypass traffic
    for (int i = 0; i < 60; i++)
      step(1'b0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, acc);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);

    full_frame("frame1");

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, frame_in[0], 1'b0, 1'b1, acc);
    reset_chk(1'b1);
    full_frame("frame_after_rst");

    // Random gaps, stalls and forced zeros across several frames
    n = 0; f0 = frames_done;
    while (frames_done < f0 + 3 && n < 3000) begin
      step(1'b1, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, acc);
      n++;
    end
    if (n >= 3000) chk("rand_frame_timeout", n, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    chk("drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
